// File: rtl/dht_sensor_reader.sv
// rtl/dht_sensor_reader.sv - single-wire DHT11/DHT22 reader with timeouts, checksum and auto-poll
// data_oe=1 means pull the pin low; the top level owns the open-drain buffer.
module dht_sensor_reader #(
   parameter int CLK_HZ        = 100_000_000,
   parameter int START11_US    = 18000,
   parameter int START22_US    = 1000,
   parameter int BIT_THRESH_US = 50,
   parameter int TIMEOUT_US    = 200,
   parameter int POLL_MS       = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mode,
   input  logic        data_in,
   output logic        data_oe,
   output logic        busy,
   output logic        valid,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [15:0] hum,
   output logic [15:0] temp,
   output logic [39:0] raw
);
   localparam logic [31:0] START11_C = 32'(64'(START11_US) * 64'(CLK_HZ) / 64'd1_000_000);
   localparam logic [31:0] START22_C = 32'(64'(START22_US) * 64'(CLK_HZ) / 64'd1_000_000);
   localparam logic [31:0] THRESH_C  = 32'(64'(BIT_THRESH_US) * 64'(CLK_HZ) / 64'd1_000_000);
   localparam logic [31:0] TIMEOUT_C = 32'(64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1_000_000);
   localparam logic [31:0] POLL_C    = 32'(64'(POLL_MS) * 64'(CLK_HZ) / 64'd1_000);
   // The synchroniser still shows the host's own low drive for a couple of cycles after release.
   localparam logic [31:0] SYNC_SETTLE = 32'd4;

   typedef enum logic [2:0] {
      IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
   } state_t;

   state_t      state, state_next;
   logic        sync1, sync2, sync3;
   logic        rise, fall;
   logic [31:0] cnt, poll_cnt;
   logic [39:0] shreg;
   logic [5:0]  idx;
   logic        mode_r;
   logic        poll_tick, launch, timeout, bit_val;
   logic        fail;
   logic [1:0]  fail_code;
   logic [7:0]  b0, b1, b2, b3, b4, csum;
   logic        csum_ok;
   logic [15:0] hum_calc, temp_calc, mag;

   assign rise      = sync2 & ~sync3;
   assign fall      = ~sync2 & sync3;
   assign timeout   = (cnt == TIMEOUT_C - 32'd1);
   assign poll_tick = (POLL_C != 32'd0) && (poll_cnt == POLL_C - 32'd1);
   assign launch    = start | poll_tick;
   assign bit_val   = (cnt > THRESH_C);

   always_comb begin
      b0      = shreg[39:32];
      b1      = shreg[31:24];
      b2      = shreg[23:16];
      b3      = shreg[15:8];
      b4      = shreg[7:0];
      csum    = b0 + b1 + b2 + b3;
      csum_ok = (csum == b4);
      if (mode_r) begin
         hum_calc  = {b0, b1};
         mag       = {1'b0, b2[6:0], b3};
         temp_calc = b2[7] ? -mag : mag;
      end else begin
         hum_calc  = {8'd0, b0} * 16'd10 + {8'd0, b1};
         mag       = {8'd0, b2} * 16'd10 + {9'd0, b3[6:0]};
         temp_calc = b3[7] ? -mag : mag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      fail       = 1'b0;
      fail_code  = 2'd0;
      case (state)
         IDLE:      if (launch) state_next = START_LOW;
         START_LOW: if (cnt == (mode_r ? START22_C : START11_C) - 32'd1) state_next = WAIT_RESP;
         WAIT_RESP: begin
            if (!sync2 && cnt >= SYNC_SETTLE) state_next = RESP_LOW;
            else if (timeout) begin fail = 1'b1; fail_code = 2'd1; end
         end
         RESP_LOW: begin
            if (rise) state_next = RESP_HIGH;
            else if (timeout) begin fail = 1'b1; fail_code = 2'd2; end
         end
         RESP_HIGH: begin
            if (fall) state_next = BIT_LOW;
            else if (timeout) begin fail = 1'b1; fail_code = 2'd2; end
         end
         BIT_LOW: begin
            if (rise) state_next = BIT_HIGH;
            else if (timeout) begin fail = 1'b1; fail_code = 2'd2; end
         end
         BIT_HIGH: begin
            if (fall) state_next = (idx == 6'd39) ? CHECK : BIT_LOW;
            else if (timeout) begin fail = 1'b1; fail_code = 2'd2; end
         end
         CHECK:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (fail) state_next = IDLE;
   end

   always_comb begin
      data_oe = (state == START_LOW);
      busy    = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         sync3    <= 1'b1;
         cnt      <= '0;
         poll_cnt <= '0;
         shreg    <= '0;
         idx      <= '0;
         mode_r   <= 1'b0;
         valid    <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'd0;
         hum      <= '0;
         temp     <= '0;
         raw      <= '0;
      end else begin
         sync1    <= data_in;
         sync2    <= sync1;
         sync3    <= sync2;
         cnt      <= (state_next != state) ? 32'd0 : cnt + 32'd1;
         poll_cnt <= (state == IDLE && POLL_C != 32'd0) ? poll_cnt + 32'd1 : 32'd0;
         valid    <= 1'b0;
         err      <= 1'b0;
         if (state == IDLE && launch) mode_r <= mode;
         if (state == RESP_HIGH && fall) idx <= 6'd0;
         if (state == BIT_HIGH && fall) begin
            shreg <= {shreg[38:0], bit_val};
            idx   <= idx + 6'd1;
         end
         if (fail) begin
            err      <= 1'b1;
            err_code <= fail_code;
         end
         if (state == CHECK) begin
            if (csum_ok) begin
               valid    <= 1'b1;
               err_code <= 2'd0;
               raw      <= shreg;
               hum      <= hum_calc;
               temp     <= temp_calc;
            end else begin
               err      <= 1'b1;
               err_code <= 2'd3;
            end
         end
      end
   end
endmodule

// File: tb/tb_dht_sensor_reader.sv
// tb/tb_dht_sensor_reader.sv - directed and randomized bench for dht_sensor_reader
// A behavioural sensor drives the line; expected values come from a plain-arithmetic model.
module tb_dht_sensor_reader;
   localparam int CLK_HZ = 1_000_000;
   localparam int TO     = 200;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic mode  = 1'b0;
   logic sens  = 1'b1;
   logic data_in;
   logic data_oe, busy, valid, err;
   logic [1:0]  err_code;
   logic [15:0] hum, temp;
   logic [39:0] raw;
   logic p_oe, p_busy, p_valid, p_err;
   logic [1:0]  p_err_code;
   logic [15:0] p_hum, p_temp;
   logic [39:0] p_raw;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int pulse_cyc = 0;
   bit busy_at_pulse = 1'b0;
   bit poll_arm = 1'b0;
   int poll_delta[2];
   int poll_n = 0;
   logic [15:0] exp_hum  = '0;
   logic [15:0] exp_temp = '0;
   logic [39:0] exp_raw  = '0;

   assign data_in = sens & ~data_oe;

   dht_sensor_reader #(.CLK_HZ(CLK_HZ)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
      .data_oe(data_oe), .busy(busy), .valid(valid), .err(err), .err_code(err_code),
      .hum(hum), .temp(temp), .raw(raw)
   );

   dht_sensor_reader #(.CLK_HZ(CLK_HZ), .POLL_MS(5)) pdut (
      .clk(clk), .rst(rst), .start(1'b0), .mode(1'b1), .data_in(1'b1),
      .data_oe(p_oe), .busy(p_busy), .valid(p_valid), .err(p_err), .err_code(p_err_code),
      .hum(p_hum), .temp(p_temp), .raw(p_raw)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) n_valid <= n_valid + 1;
      if (err) n_err <= n_err + 1;
      if (valid || err) begin
         pulse_cyc     <= cyc;
         busy_at_pulse <= busy;
      end
   end

   initial begin : poll_mon
      int  fall_cyc;
      bit  prev;
      fall_cyc = -1;
      prev     = 1'b0;
      wait (poll_arm);
      while (poll_n < 2) begin
         @(posedge clk); #1;
         if (prev && !p_busy) fall_cyc = cyc;
         if (!prev && p_busy && fall_cyc >= 0) begin
            poll_delta[poll_n] = cyc - fall_cyc;
            poll_n++;
         end
         prev = p_busy;
      end
   end

   function automatic bit ref_ok(input logic [39:0] f);
      int s;
      s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
      return (s % 256) == int'(f[7:0]);
   endfunction

   function automatic logic [15:0] ref_hum(input logic m, input logic [39:0] f);
      int b0, b1;
      b0 = int'(f[39:32]);
      b1 = int'(f[31:24]);
      return m ? 16'(b0 * 256 + b1) : 16'(b0 * 10 + b1);
   endfunction

   function automatic logic [15:0] ref_temp(input logic m, input logic [39:0] f);
      int b2, b3, v;
      b2 = int'(f[23:16]);
      b3 = int'(f[15:8]);
      if (m) begin
         v = (b2 % 128) * 256 + b3;
         if (b2 >= 128) v = -v;
      end else begin
         v = b2 * 10 + (b3 % 128);
         if (b3 >= 128) v = -v;
      end
      return 16'(v);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic hold(input logic level, input int n);
      sens = level;
      step(n);
   endtask

   task automatic pulse_start(input logic m);
      mode  = m;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic sensor(input logic [39:0] f, input int stall, input bit respond,
                         output int low_len, output int fall_cyc);
      int t;
      t = 0;
      low_len = 0;
      while (!data_oe && t < 100) begin step(1); t++; end
      check("oe_asserted", data_oe, 1);
      while (data_oe && low_len < 40000) begin low_len++; step(1); end
      fall_cyc = cyc;
      if (respond) begin
         hold(1'b1, 30);
         hold(1'b0, 80);
         hold(1'b1, 80);
         for (int i = 0; i < 40; i++) begin
            if (i == stall) begin
               sens = 1'b1;
               return;
            end
            hold(1'b0, 50);
            hold(1'b1, f[39-i] ? 70 : 26);
         end
         hold(1'b0, 50);
         sens = 1'b1;
      end
   endtask

   task automatic wait_done(input int budget, input int v0, input int e0);
      int t;
      t = 0;
      while (n_valid + n_err == v0 + e0 && t < budget) begin step(1); t++; end
      check("done_in_time", (n_valid + n_err != v0 + e0), 1);
   endtask

   task automatic run_frame(input string tag, input logic m, input logic [39:0] f, input int exp_low);
      int v0, e0, low, fc;
      bit ok;
      v0 = n_valid;
      e0 = n_err;
      pulse_start(m);
      sensor(f, -1, 1'b1, low, fc);
      wait_done(300, v0, e0);
      ok = ref_ok(f);
      if (ok) begin
         exp_hum  = ref_hum(m, f);
         exp_temp = ref_temp(m, f);
         exp_raw  = f;
      end
      check({tag, "_low"}, low, exp_low);
      check({tag, "_valid"}, n_valid - v0, ok ? 1 : 0);
      check({tag, "_err"}, n_err - e0, ok ? 0 : 1);
      check({tag, "_code"}, err_code, ok ? 0 : 3);
      check({tag, "_hum"}, hum, exp_hum);
      check({tag, "_temp"}, temp, exp_temp);
      check({tag, "_raw"}, raw, exp_raw);
      check({tag, "_busy_at_pulse"}, busy_at_pulse, 0);
      step(3);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin : main
      logic [39:0] f;
      int low, fc, v0, e0, dt;

      step(5);
      check("rst_ctrl", {data_oe, busy, valid, err, err_code}, 0);
      check("rst_hum", hum, 0);
      check("rst_temp", temp, 0);
      check("rst_raw", raw, 0);
      rst = 1'b0;
      step(2);

      pulse_start(1'b1);
      step(100);
      check("startlow_oe", data_oe, 1);
      rst = 1'b1;
      step(1);
      check("rstmid_ctrl", {data_oe, busy, valid, err, err_code}, 0);
      check("rstmid_hum", hum, 0);
      check("rstmid_temp", temp, 0);
      check("rstmid_raw", raw, 0);
      rst = 1'b0;
      step(1);
      poll_arm = 1'b1;

      run_frame("dht11", 1'b0, 40'h3700190050, 18000);
      run_frame("dht22", 1'b1, 40'h028C806573, 1000);
      run_frame("csum", 1'b0, 40'h3700190051, 18000);

      v0 = n_valid; e0 = n_err;
      pulse_start(1'b1);
      sensor(40'h0, -1, 1'b0, low, fc);
      wait_done(400, v0, e0);
      dt = pulse_cyc - fc;
      check("noresp_code", err_code, 1);
      check("noresp_time", (dt >= TO && dt <= TO + 3), 1);
      check("noresp_valid", n_valid - v0, 0);
      check("noresp_hum", hum, exp_hum);

      v0 = n_valid; e0 = n_err;
      pulse_start(1'b1);
      sensor(40'hA5C3F00F67, 20, 1'b1, low, fc);
      wait_done(400, v0, e0);
      check("stall_code", err_code, 2);
      check("stall_oe", data_oe, 0);
      check("stall_busy", busy, 0);
      check("stall_valid", n_valid - v0, 0);
      check("stall_raw", raw, exp_raw);

      f = 40'h019000FA8B;
      v0 = n_valid; e0 = n_err;
      pulse_start(1'b1);
      step(10);
      pulse_start(1'b0);
      step(10);
      pulse_start(1'b0);
      sensor(f, -1, 1'b1, low, fc);
      wait_done(300, v0, e0);
      exp_hum  = ref_hum(1'b1, f);
      exp_temp = ref_temp(1'b1, f);
      exp_raw  = f;
      check("busy_valid", n_valid - v0, 1);
      check("busy_err", n_err - e0, 0);
      check("busy_hum", hum, exp_hum);
      check("busy_temp", temp, exp_temp);
      step(5);
      check("busy_idle", busy, 0);

      for (int k = 0; k < 3; k++) begin
         f[39:8] = $urandom;
         f[7:0]  = f[39:32] + f[31:24] + f[23:16] + f[15:8];
         if ($urandom_range(0, 3) == 0) f[7:0] = f[7:0] ^ 8'h01;
         run_frame("rand", 1'b1, f, 1000);
      end

      check("poll_count", (poll_n >= 2), 1);
      check("poll_period0", poll_delta[0], 5000);
      check("poll_period1", poll_delta[1], 5000);
      check("poll_code", p_err_code, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
